// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the carry-save accumulator.
// Holds the FSM state type, resolve-cycle sizing and parameter legality checks.
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int calc_k(input int acc_w, input int chunk);
        return acc_w / chunk;
    endfunction

    // A single-chunk resolve still needs a 1-bit index register.
    function automatic int calc_idx_w(input int acc_w, input int chunk);
        int k;
        k = acc_w / chunk;
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    function automatic bit params_ok(input int width, input int acc_w, input int chunk);
        return (acc_w >= width) && (chunk > 0) && ((acc_w % chunk) == 0);
    endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational W-bit 3:2 compressor, one full-adder cell per bit.
// o_c is the unshifted per-bit carry; the caller applies the weight shift.
module csa_row #(
    parameter int W = 12
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_s,
    output logic [W-1:0] o_c
);

    for (genvar g = 0; g < W; g++) begin : g_fa
        assign o_s[g] = i_a[g] ^ i_b[g] ^ i_c[g];
        assign o_c[g] = (i_a[g] & i_b[g]) | (i_a[g] & i_c[g]) | (i_b[g] & i_c[g]);
    end

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: carry-save compression, then a K-cycle chunked CPA.
// Latency K cycles from the last accept to out_valid; one operand per cycle while accumulating.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 12,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int K     = calc_k(ACC_W, CHUNK);
    localparam int IDX_W = calc_idx_w(ACC_W, CHUNK);

    if (!params_ok(WIDTH, ACC_W, CHUNK)) begin : g_bad_params
        $error("csa_accumulator: need ACC_W >= WIDTH and ACC_W divisible by CHUNK");
    end

    state_t             r_state;
    logic [ACC_W-1:0]   r_sum;
    logic [ACC_W-1:0]   r_carry;
    logic [ACC_W-1:0]   r_result;
    logic               r_ovf;
    logic               r_cpa_c;
    logic [IDX_W-1:0]   r_idx;

    logic [ACC_W-1:0]   w_ext;
    logic [ACC_W-1:0]   w_s;
    logic [ACC_W-1:0]   w_c;
    logic               w_accept;
    logic               w_last_chunk;
    logic [CHUNK-1:0]   w_sum_chunk;
    logic [CHUNK-1:0]   w_carry_chunk;
    logic [CHUNK:0]     w_chunk_sum;

    assign w_ext = ACC_W'(in_data);

    csa_row #(.W(ACC_W)) u_row (
        .i_a (r_sum),
        .i_b (r_carry),
        .i_c (w_ext),
        .o_s (w_s),
        .o_c (w_c)
    );

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_result;
    assign out_ovf   = r_ovf;

    assign w_accept      = in_valid & in_ready;
    assign w_last_chunk  = (r_idx == IDX_W'(K - 1));
    assign w_sum_chunk   = r_sum[r_idx * CHUNK +: CHUNK];
    assign w_carry_chunk = r_carry[r_idx * CHUNK +: CHUNK];
    assign w_chunk_sum   = {1'b0, w_sum_chunk} + {1'b0, w_carry_chunk} + (CHUNK + 1)'(r_cpa_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ACCUM;
            r_sum    <= '0;
            r_carry  <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_cpa_c  <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_sum   <= w_s;
                        r_carry <= w_c << 1;
                        // Carry leaving the top bit is worth 2^ACC_W: the sum has overflowed.
                        r_ovf   <= r_ovf | w_c[ACC_W-1];
                        if (in_last) begin
                            r_state <= RESOLVE;
                            r_idx   <= '0;
                            r_cpa_c <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    r_result[r_idx * CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
                    r_cpa_c <= w_chunk_sum[CHUNK];
                    if (w_last_chunk) begin
                        r_ovf   <= r_ovf | w_chunk_sum[CHUNK];
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_sum    <= '0;
                        r_carry  <= '0;
                        r_ovf    <= 1'b0;
                        r_result <= '0;
                        r_state  <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Randomised and directed checks of csa_accumulator against an integer-sum reference model.
module tb_csa_accumulator;

    localparam int WIDTH = 8;
    localparam int ACC_W = 12;
    localparam int K     = 3;
    localparam int MODV  = 4096;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int q_ops[$];

    csa_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives q_ops as one group with up to gap_max idle cycles before each operand.
    task automatic push_ops(input int gap_max, output int exp_sum);
        int gaps;
        int guard;
        bit acc;
        exp_sum = 0;
        for (int i = 0; i < q_ops.size(); i++) begin
            gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(0, 1));
                in_data  = WIDTH'($urandom_range(0, 255));
                tick();
            end
            in_valid = 1'b1;
            in_data  = WIDTH'(q_ops[i]);
            in_last  = (i == q_ops.size() - 1);
            guard = 0;
            do begin
                acc = in_ready;
                tick();
                guard++;
            end while (!acc && guard < 50);
            if (!acc) chk("accept_timeout", 0, 1);
            exp_sum += q_ops[i];
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_group(input string tag, input int exp_sum, input int hold);
        int lat;
        logic [ACC_W-1:0] d0;
        logic o0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, K);
        chk({tag, "_data"}, out_data, exp_sum % MODV);
        chk({tag, "_ovf"}, out_ovf, (exp_sum > MODV - 1) ? 1 : 0);
        chk({tag, "_rdy_low"}, in_ready, 0);
        d0 = out_data;
        o0 = out_ovf;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 8'd7;
            tick();
            chk({tag, "_hold_data"}, out_data, d0);
            chk({tag, "_hold_ovf"}, out_ovf, o0);
            chk({tag, "_hold_rdy"}, in_ready, 0);
            chk({tag, "_hold_vld"}, out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_post_vld"}, out_valid, 0);
        chk({tag, "_post_rdy"}, in_ready, 1);
        chk({tag, "_post_data"}, out_data, 0);
    endtask

    task automatic run_group(input string tag, input int gap_max, input int hold);
        int s;
        push_ops(gap_max, s);
        finish_group(tag, s, hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);

        q_ops = '{1, 2, 3};
        run_group("g123", 0, 0);

        q_ops = {};
        for (int i = 0; i < 16; i++) q_ops.push_back(255);
        run_group("g16x255", 0, 0);
        q_ops.push_back(255);
        run_group("g17x255", 0, 0);

        q_ops = '{165};
        run_group("gA5", 0, 0);

        q_ops = '{2, 3};
        run_group("ghold", 0, 5);
        q_ops = '{4, 5};
        run_group("g45", 0, 0);

        q_ops = '{50, 60};
        push_ops(0, s);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_ovf", out_ovf, 0);
        q_ops = '{10, 20};
        run_group("g1020", 0, 0);

        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < 3; i++) tick();
        in_last = 1'b0;
        chk("lastnovld_rdy", in_ready, 1);
        chk("lastnovld_vld", out_valid, 0);
        q_ops = '{9};
        run_group("g9", 0, 0);

        for (int g = 0; g < 25; g++) begin
            int n;
            n = $urandom_range(1, 20);
            q_ops = {};
            for (int i = 0; i < n; i++) q_ops.push_back($urandom_range(0, 255));
            run_group($sformatf("rnd%0d", g), 2, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Multi-operand unsigned accumulator built on carry-save arithmetic. A stream of WIDTH-bit operands is compressed one per cycle into redundant sum/carry vectors by a row of full-adder cells (3:2 compression). When the last operand is accepted, the vectors are resolved by a chunked, multi-cycle carry-propagate adder. The block is the parametrised, streaming successor of the single-bit full adder cell and is the first carry-save datapath in the design with handshakes and state.

## Interface
Parameters:
- WIDTH, 8, operand width in bits.
- ACC_W, 12, accumulator/result width; must satisfy ACC_W >= WIDTH.
- CHUNK, 4, carry-propagate chunk width; ACC_W % CHUNK == 0; K = ACC_W/CHUNK resolve cycles.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  unsigned operand, zero-extended to ACC_W.
- in_last  in  1  marks the final operand of a group; qualified by in_valid & in_ready.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  (sum of the group) mod 2^ACC_W.
- out_ovf  out  1  the true sum exceeded 2^ACC_W - 1.

## Operation
- States: ACCUM, RESOLVE, DONE. Reset enters ACCUM with sum = carry = 0, ovf = 0, chunk index = 0.
- ACCUM:
  - in_ready = 1.
  - On accept: sum' = s, carry' = (c << 1) mod 2^ACC_W, where s and c are the per-bit full-adder outputs of (sum, carry, zext(in_data)).
  - A 1 shifted out of carry bit ACC_W-1 sets the sticky ovf flag.
  - An accept with in_last = 1 moves to RESOLVE with chunk index = 0 and CPA carry = 0.
  - in_last is ignored unless the handshake completes.
- RESOLVE:
  - in_ready = 0.
  - Each cycle adds chunk i of sum plus chunk i of carry plus the CPA carry, writes chunk i of the result register, and latches the chunk carry-out.
  - After chunk K-1, the final carry-out is ORed into ovf and the state moves to DONE.
- DONE:
  - out_valid = 1; out_data and out_ovf are held stable, and in_ready = 0.
  - On out_valid & out_ready: clear sum, carry, ovf and the result register, then return to ACCUM.
- out_data holds the last result (or 0 after reset) outside DONE; consumers qualify it with out_valid.
- in_valid while in_ready = 0 has no effect. No operand is lost or double-counted.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_ovf = 0.
- Reset asserted in any state, including mid-RESOLVE or DONE, has these effects on the next edge:
  - The partial result is discarded and all outputs return to their reset values.
- Throughput: one operand per cycle in ACCUM.
- Latency: with the last operand accepted on edge E, RESOLVE occupies edges E+1..E+K and out_valid is high after edge E+K.
  - Default parameters: K = 3, so out_valid is high 3 cycles after the last accept.
- in_ready returns to 1 on the cycle after the out handshake edge. Minimum gap between groups is K+1 cycles.
- A group may contain one operand; its in_last arrives with that operand.

## Structure
- Shared package csa_pkg:
  - state enum {ACCUM, RESOLVE, DONE}.
  - Function computing K and the chunk-index width.
  - Parameter legality checks (ACC_W >= WIDTH, ACC_W % CHUNK == 0).
- Sub-module csa_row:
  - Parametrised ACC_W-bit 3:2 compressor, built as one full-adder cell per bit.
  - Outputs s and the unshifted c.
  - Purely combinational; instantiated once.
- The chunk CPA is inline logic in csa_accumulator.

## Test plan
All scenarios use WIDTH=8, ACC_W=12, CHUNK=4.
- Accept 1, 2, 3 (last on 3) back-to-back -> out_data = 6, out_ovf = 0, out_valid rises exactly 3 cycles after the last accept.
- 16 operands of 255 -> out_data = 4080 (0xFF0), out_ovf = 0.
- 17 operands of 255 -> out_data = 239, out_ovf = 1.
- Single operand 0xA5 with in_last -> out_data = 165.
- Hold out_ready = 0 for 5 cycles in DONE while driving in_valid = 1 and in_data = 7:
  - out_data and out_ovf stay stable and in_ready = 0.
  - After release, the next group 4, 5 -> 9 (the 7 is not counted).
- Assert rst for 1 cycle mid-RESOLVE:
  - Outputs return to reset values on the next edge and in_ready = 1.
  - The following group 10, 20 -> out_data = 30, out_ovf = 0.
- in_last = 1 with in_valid = 0 -> no state change; a later valid 9 with in_last -> out_data = 9.
